// File: rtl/sll_iter.sv
// -----------------------------------------------------------------------------
// sll_iter -- iterative logical left shifter
//
// Computes (i_operand_a << i_operand_b) with zero fill by walking one barrel
// stage per clock. The latency is always SHAMT_W cycles from acceptance to
// o_valid, whatever the shift amount is, so downstream timing never depends
// on the data.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous, active-low reset
//   i_start      request valid; accepted when high together with o_ready
//   i_operand_a  data to shift (WIDTH bits)
//   i_operand_b  left-shift amount (SHAMT_W bits)
//   i_flush      synchronous abort; wins over i_start and i_ready
//   i_ready      consumer takes the result when high with o_valid
//   o_ready      idle, able to accept a request
//   o_valid      o_sll_data holds a completed result
//   o_sll_data   working data register (a result only while o_valid)
// -----------------------------------------------------------------------------
module sll_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_operand_a,
    input  logic [SHAMT_W-1:0] i_operand_b,
    input  logic               i_flush,
    input  logic               i_ready,
    output logic               o_ready,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_sll_data
);

    // The stage counter only has to reach SHAMT_W-1.
    localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_r;
    logic [WIDTH-1:0]   data_r;
    logic [SHAMT_W-1:0] amt_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   stage_data_s;

    // One barrel stage: shift by 2^cnt when the matching amount bit is set.
    always_comb begin
        stage_data_s = data_r;
        if (amt_r[cnt_r]) begin
            stage_data_s = data_r << (32'd1 << cnt_r);
        end else begin
            stage_data_s = data_r;
        end
    end

    // Control FSM together with the operand, amount and stage registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            data_r  <= '0;
            amt_r   <= '0;
            cnt_r   <= '0;
        end else if (i_flush) begin
            // Abort clears everything so no trace of the operation survives.
            state_r <= ST_IDLE;
            data_r  <= '0;
            amt_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        data_r  <= i_operand_a;
                        amt_r   <= i_operand_b;
                        cnt_r   <= '0;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    data_r <= stage_data_s;
                    if (cnt_r == LAST_STAGE) begin
                        cnt_r   <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    // Result and o_valid hold for as long as the consumer stalls.
                    if (i_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    data_r  <= '0;
                    amt_r   <= '0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Handshake outputs are pure decodes of the registered state.
    assign o_ready    = (state_r == ST_IDLE);
    assign o_valid    = (state_r == ST_DONE);
    assign o_sll_data = data_r;

endmodule

// File: tb/tb_sll_iter.sv
// -----------------------------------------------------------------------------
// tb_sll_iter -- self-checking bench for sll_iter (WIDTH=32, SHAMT_W=5)
//
// A transaction-level model tracks idle / busy(countdown) / done and the
// expected product (a << b) mod 2^32; every cycle the DUT handshake and data
// are compared against it. Directed cases cover the corner behaviour, then a
// randomized run with stalls, flushes and operand noise follows.
// -----------------------------------------------------------------------------
module tb_sll_iter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [4:0]  op_b;
    logic        flush;
    logic        rdy_in;
    logic        rdy_out;
    logic        valid;
    logic [31:0] data;

    sll_iter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_operand_a (op_a),
        .i_operand_b (op_b),
        .i_flush     (flush),
        .i_ready     (rdy_in),
        .o_ready     (rdy_out),
        .o_valid     (valid),
        .o_sll_data  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt_r  = 0;
    int err_cnt_r  = 0;

    // Reference model: 0 idle, 1 busy (countdown of edges left), 2 done.
    int          m_phase    = 0;
    int          m_left     = 0;
    logic [31:0] m_res      = 32'd0;
    bit          m_zero     = 1'b1;
    int          m_accepted = 0;
    int          m_results  = 0;
    int          dut_results = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt_r++;
        if (got !== exp) begin
            err_cnt_r++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_zero  = 1'b1;
    endtask

    // Compare all outputs against the model state.
    task automatic check_outputs();
        check("ready", {31'd0, rdy_out}, {31'd0, (m_phase == 0)});
        check("valid", {31'd0, valid},   {31'd0, (m_phase == 2)});
        if (m_phase == 2) check("result", data, m_res);
        if (m_zero)       check("cleared", data, 32'd0);
    endtask

    // One clock: count observed handshakes, advance model on the edge, check.
    task automatic cycle();
        if (rst_n && valid && rdy_in && !flush) dut_results++;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_left  = 5;
                    m_res   = op_a << op_b;
                    m_zero  = 1'b0;
                    m_accepted++;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                2: if (rdy_in) begin
                    m_phase = 0;
                    m_results++;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        check_outputs();
    endtask

    // Directed request: accept, fixed latency, optional stall with ignored start.
    task automatic run_req(input logic [31:0] a, input logic [4:0] b,
                           input logic [31:0] exp, input int stall);
        start  = 1'b1;
        op_a   = a;
        op_b   = b;
        rdy_in = 1'b1;
        cycle();
        start = 1'b0;
        rdy_in = (stall == 0);
        for (int i = 0; i < 5; i++) begin
            op_a = $urandom;
            op_b = 5'($urandom);
            check("early_valid", {31'd0, valid}, 32'd0);
            cycle();
        end
        check("lat5_valid", {31'd0, valid}, 32'd1);
        check("lat5_data", data, exp);
        for (int i = 0; i < stall; i++) begin
            start = 1'b1;
            cycle();
            check("hold_data", data, exp);
            check("hold_valid", {31'd0, valid}, 32'd1);
        end
        start  = 1'b0;
        rdy_in = 1'b1;
        cycle();
        check("back_idle", {31'd0, rdy_out}, 32'd1);
    endtask

    initial begin
        int  rand_acc;
        bit  done_rand;
        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = 32'd0;
        op_b   = 5'd0;
        flush  = 1'b0;
        rdy_in = 1'b0;
        #2;
        check("rst_ready", {31'd0, rdy_out}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        run_req(32'h0000_0001, 5'd31, 32'h8000_0000, 0);
        run_req(32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, 0);
        run_req(32'h1234_5678, 5'd0,  32'h1234_5678, 0);
        run_req(32'h0000_00FF, 5'd12, 32'h000F_F000, 3);

        // Flush on the second SHIFT cycle.
        start = 1'b1; op_a = 32'hA5A5_A5A5; op_b = 5'd7; rdy_in = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_idle", {31'd0, rdy_out}, 32'd1);
        check("flush_data", data, 32'd0);
        repeat (6) begin
            cycle();
            check("flush_novalid", {31'd0, valid}, 32'd0);
        end
        run_req(32'h0000_0003, 5'd1, 32'h0000_0006, 0);

        // Asynchronous reset in the middle of SHIFT.
        start = 1'b1; op_a = 32'hDEAD_BEEF; op_b = 5'd9;
        cycle();
        start = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_ready", {31'd0, rdy_out}, 32'd1);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_data", data, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            cycle();
            check("arst_novalid", {31'd0, valid}, 32'd0);
        end
        run_req(32'h8000_0001, 5'd1, 32'h0000_0002, 0);

        // Randomized traffic with stalls, rare flushes and operand noise.
        rand_acc  = m_accepted;
        done_rand = 1'b0;
        for (int c = 0; c < 40000; c++) begin
            start  = ($urandom_range(0, 3) != 0);
            op_a   = $urandom;
            op_b   = 5'($urandom);
            rdy_in = ($urandom_range(0, 4) < 3);
            flush  = ($urandom_range(0, 99) == 0);
            cycle();
            if (m_accepted - rand_acc >= 2000) begin
                done_rand = 1'b1;
                break;
            end
        end
        check("rand_budget", {31'd0, done_rand}, 32'd1);

        // Drain and compare result counts.
        start = 1'b0; flush = 1'b0; rdy_in = 1'b1;
        repeat (8) cycle();
        check("result_count", 32'(dut_results), 32'(m_results));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt_r, err_cnt_r);
        $finish;
    end

endmodule
